// File: rtl/seven_seg_pkg.sv
// Shared constants, digit-code type and code sanitiser for the seven-segment display blocks.
package seven_seg_pkg;

  localparam int N_DIGITS = 4;
  localparam int DIGIT_W  = 2;
  localparam int NUM_W    = 4;

  typedef logic [NUM_W-1:0] digit_code_t;

  localparam digit_code_t NUM_BLANK = 4'hA;
  localparam digit_code_t NUM_DASH  = 4'hF;

  // Codes the decoder has no glyph for (B..E) are shown as blank.
  function automatic digit_code_t sanitise_code(input digit_code_t code);
    if ((code >= 4'hB) && (code <= 4'hE)) return NUM_BLANK;
    return code;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running 0..DIV-1 counter with a tick on the last count; shared by display scanners.
module scan_prescaler #(
  parameter int DIV   = 100000,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (tick) count <= '0;
    else count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit scanner feeding one shared seven-segment decoder, with tear-free double buffering.
// Optional leading-zero suppression: define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIV          = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         value_in,
  input  logic                load,
  input  logic [N_DIGITS-1:0] digit_en,
  output logic [NUM_W-1:0]    num,
  output logic [DIGIT_W-1:0]  digit,
  output logic                en,
  output logic                frame_done
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]   pre_cnt;
  logic               tick;
  logic [DIGIT_W-1:0] slot;
  logic [15:0]        active;
  logic [15:0]        pending;
  logic               pend_vld;

  logic [DIGIT_W-1:0] slot_nxt;
  logic [CNT_W-1:0]   pre_nxt;
  logic [15:0]        act_nxt;
  logic               wrap;

  scan_prescaler #(.DIV(DIV), .CNT_W(CNT_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .count (pre_cnt),
    .tick  (tick)
  );

  // Code shown for one digit of a value, after sanitising and optional zero suppression.
  function automatic digit_code_t pick_code(input logic [15:0] val, input logic [DIGIT_W-1:0] idx);
    digit_code_t c [N_DIGITS];
`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic zero_above;
    logic lead;
`endif
    for (int i = 0; i < N_DIGITS; i++) c[i] = sanitise_code(val[4*i +: 4]);
`ifdef SEVEN_SEG_LZ_BLANK_EN
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      lead       = zero_above && (c[i] == 4'h0);
      zero_above = zero_above && ((c[i] == 4'h0) || (c[i] == NUM_BLANK));
      if (lead) c[i] = NUM_BLANK;
    end
`endif
    return c[idx];
  endfunction

  // Post-edge view of slot, prescaler and active value so outputs line up with the edge.
  always_comb begin
    slot_nxt = tick ? slot + DIGIT_W'(1) : slot;
    pre_nxt  = tick ? '0 : pre_cnt + CNT_W'(1);
    wrap     = tick && (slot == DIGIT_W'(N_DIGITS - 1));
    act_nxt  = active;
    if (wrap) begin
      if (load) act_nxt = value_in;
      else if (pend_vld) act_nxt = pending;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= '0;
      active     <= {N_DIGITS{NUM_BLANK}};
      pending    <= {N_DIGITS{NUM_BLANK}};
      pend_vld   <= 1'b0;
      num        <= NUM_BLANK;
      en         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      slot       <= slot_nxt;
      active     <= act_nxt;
      frame_done <= wrap;
      num        <= pick_code(act_nxt, slot_nxt);
      en         <= digit_en[slot_nxt] && (pre_nxt >= BLANK_C);
      if (wrap) begin
        pend_vld <= 1'b0;
      end else if (load) begin
        pending  <= value_in;
        pend_vld <= 1'b1;
      end
    end
  end

  assign digit = slot;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised self-checking bench for seven_seg_scanner against a frame-level reference model.
module tb_seven_seg_scanner;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  num;
  logic [1:0]  digit;
  logic        en;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model: edges since reset, displayed value, pending buffer.
  int          k;
  logic [15:0] shown, pend;
  bit          pvld;
  logic [1:0]  e_digit;
  logic [3:0]  e_num;
  logic        e_en, e_fd;

  seven_seg_scanner #(.DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .load       (load),
    .digit_en   (digit_en),
    .num        (num),
    .digit      (digit),
    .en         (en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_code(input logic [15:0] v, input int d);
    logic [3:0] n [4];
    for (int i = 0; i < 4; i++) begin
      n[i] = v[4*i +: 4];
      if (n[i] >= 4'd11 && n[i] <= 4'd14) n[i] = 4'hA;
    end
`ifdef SEVEN_SEG_LZ_BLANK_EN
    if (d > 0 && n[d] == 4'h0) begin
      bit all_zero_or_blank;
      all_zero_or_blank = 1'b1;
      for (int j = d + 1; j < 4; j++)
        if (!(n[j] == 4'h0 || n[j] == 4'hA)) all_zero_or_blank = 1'b0;
      if (all_zero_or_blank) return 4'hA;
    end
`endif
    return n[d];
  endfunction

  task automatic model_reset();
    k = 0; shown = 16'hAAAA; pend = 16'hAAAA; pvld = 1'b0;
  endtask

  // Drives inputs for one edge, advances the model, then waits 1 time unit past the edge.
  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] m);
    load = ld; value_in = v; digit_en = m;
    @(posedge clk);
    k++;
    e_fd = (k % FRAME == 0);
    if (e_fd) begin
      if (ld) begin shown = v; pvld = 1'b0; end
      else if (pvld) begin shown = pend; pvld = 1'b0; end
    end else if (ld) begin
      pend = v; pvld = 1'b1;
    end
    e_digit = 2'((k / DIV) % 4);
    e_en    = m[e_digit] && ((k % DIV) >= BLANK);
    e_num   = ref_code(shown, e_digit);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({digit, num, en, frame_done} !== {2'd0, 4'hA, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset: got digit=%0d num=%h en=%b fd=%b want 0 A 0 0", digit, num, en, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_load_display();
    step(1'b1, 16'h1234, 4'hF);
    for (int c = 0; c < 2 * FRAME && !(e_fd && shown == 16'h1234); c++) begin
      step(1'b0, 16'h0, 4'hF);
      total++;
      if ({digit, num, en, frame_done} !== {e_digit, e_num, e_en, e_fd}) begin
        bad++; $display("FAIL load_wait: got %0d %h %b %b want %0d %h %b %b", digit, num, en, frame_done, e_digit, e_num, e_en, e_fd);
      end
    end
    for (int d = 0; d < 4; d++) begin
      for (int p = 0; p < DIV; p++) begin
        total++;
        if ({digit, num, en} !== {2'(d), 4'(4 - d), (p >= BLANK)}) begin
          bad++; $display("FAIL load_frame d%0d p%0d: got %0d %h %b want %0d %h %b", d, p, digit, num, en, d, 4 - d, p >= BLANK);
        end
        step(1'b0, 16'h0, 4'hF);
      end
    end
  endtask

  task automatic test_tearing();
    for (int c = 0; c < FRAME && e_digit != 2'd1; c++) step(1'b0, 16'h0, 4'hF);
    step(1'b1, 16'h5678, 4'hF);
    for (int c = 0; c < FRAME && !e_fd; c++) begin
      total++;
      if ({digit, num, en, frame_done} !== {e_digit, e_num, e_en, e_fd}) begin
        bad++; $display("FAIL tearing: got %0d %h %b %b want %0d %h %b %b", digit, num, en, frame_done, e_digit, e_num, e_en, e_fd);
      end
      if (digit != 2'd0) begin
        total++;
        if (num !== 4'(4 - int'(digit))) begin
          bad++; $display("FAIL tearing_old d%0d: got %h want %h", digit, num, 4'(4 - int'(digit)));
        end
      end
      step(1'b0, 16'h0, 4'hF);
    end
    total++;
    if ({frame_done, digit, num} !== {1'b1, 2'd0, 4'h8}) begin
      bad++; $display("FAIL tearing_wrap: got fd=%b digit=%0d num=%h want 1 0 8", frame_done, digit, num);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 16'h1111, 4'hF);
    step(1'b0, 16'h0, 4'hF);
    step(1'b1, 16'h2222, 4'hF);
    for (int c = 0; c < 2 * FRAME; c++) begin
      step(1'b0, 16'h0, 4'hF);
      if (k % FRAME > 0 || e_fd) begin
        total++;
        if (num === 4'h1) begin
          bad++; $display("FAIL b2b_first: got num=%h want not 1", num);
        end
      end
    end
    total++;
    if (num !== 4'h2) begin
      bad++; $display("FAIL b2b_last: got num=%h want 2", num);
    end
    while ((k + 1) % FRAME != 0) step(1'b0, 16'h0, 4'hF);
    step(1'b1, 16'h9876, 4'hF);
    total++;
    if ({frame_done, digit, num} !== {1'b1, 2'd0, 4'h6}) begin
      bad++; $display("FAIL bypass: got fd=%b digit=%0d num=%h want 1 0 6", frame_done, digit, num);
    end
    for (int c = 0; c < FRAME; c++) begin
      step(1'b0, 16'h0, 4'hF);
      total++;
      if ({digit, num, en, frame_done} !== {e_digit, e_num, e_en, e_fd}) begin
        bad++; $display("FAIL bypass_frame: got %0d %h %b %b want %0d %h %b %b", digit, num, en, frame_done, e_digit, e_num, e_en, e_fd);
      end
    end
  endtask

  task automatic test_sanitise_mask();
    logic [3:0] want [4];
    want[0] = 4'hA; want[1] = 4'hA; want[2] = 4'h0; want[3] = 4'hF;
    step(1'b1, 16'hF0CB, 4'b1011);
    for (int c = 0; c < FRAME && !e_fd; c++) step(1'b0, 16'h0, 4'b1011);
    for (int c = 0; c < FRAME; c++) begin
      total++;
      if (num !== want[digit] || (digit == 2'd2 && en !== 1'b0)) begin
        bad++; $display("FAIL sanitise d%0d: got num=%h en=%b want num=%h", digit, num, en, want[digit]);
      end
      step(1'b0, 16'h0, 4'b1011);
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] want [4];
`ifdef SEVEN_SEG_LZ_BLANK_EN
    want[3] = 4'hA; want[2] = 4'hA;
`else
    want[3] = 4'h0; want[2] = 4'h0;
`endif
    want[1] = 4'h7; want[0] = 4'h0;
    step(1'b1, 16'h0070, 4'hF);
    for (int c = 0; c < FRAME && !e_fd; c++) step(1'b0, 16'h0, 4'hF);
    for (int c = 0; c < FRAME; c++) begin
      total++;
      if (num !== want[digit]) begin
        bad++; $display("FAIL lz d%0d: got %h want %h", digit, num, want[digit]);
      end
      step(1'b0, 16'h0, 4'hF);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit ld;
      ld = ($urandom_range(0, 9) == 0);
      step(ld, 16'($urandom), (c % 50 < 25) ? 4'hF : 4'($urandom));
      total++;
      if ({digit, num, en, frame_done} !== {e_digit, e_num, e_en, e_fd}) begin
        bad++; $display("FAIL random c%0d: got %0d %h %b %b want %0d %h %b %b", c, digit, num, en, frame_done, e_digit, e_num, e_en, e_fd);
      end
    end
  endtask

  task automatic test_midframe_reset();
    step(1'b1, 16'h4321, 4'hF);
    for (int c = 0; c < 3 * FRAME && !(shown == 16'h4321 && e_digit == 2'd2 && e_en); c++)
      step(1'b0, 16'h0, 4'hF);
    total++;
    if ({digit, en} !== {2'd2, 1'b1}) begin
      bad++; $display("FAIL mid_pre: got digit=%0d en=%b want 2 1", digit, en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({digit, num, en, frame_done} !== {2'd0, 4'hA, 1'b0, 1'b0}) begin
      bad++; $display("FAIL mid_async: got %0d %h %b %b want 0 A 0 0", digit, num, en, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 2 * FRAME; c++) begin
      step(1'b0, 16'h0, 4'hF);
      total++;
      if ({digit, num, en, frame_done} !== {e_digit, 4'hA, e_en, e_fd}) begin
        bad++; $display("FAIL mid_after: got %0d %h %b %b want %0d A %b %b", digit, num, en, frame_done, e_digit, e_en, e_fd);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_display();
    test_tearing();
    test_back_to_back();
    test_sanitise_mask();
    test_leading_zero();
    test_random();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
